// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-memory initiator.
// State encoding, counter width and effective-address helper.
package mem_access_unit_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  function automatic logic [7:0] calc_ea(
    input logic [7:0] b,
    input logic [7:0] o
  );
    return b + o;
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store initiator for the memorydata port.
// Holds Rm/Wm for ACC_CYCLES cycles, then pulses done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACC_CYCLES = 1,
  parameter int MEM_DEPTH  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_store,
  input  logic [7:0] base,
  input  logic [7:0] offset,
  input  logic [7:0] store_data,
  input  logic [7:0] Data_out,
  output logic       Rm,
  output logic       Wm,
  output logic [7:0] address,
  output logic [7:0] RegVal,
  output logic [7:0] load_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(ACC_CYCLES - 1);

  state_t           state, n_state;
  logic [CNT_W-1:0] cnt, n_cnt;
  logic             n_rm, n_wm, n_busy;
  logic             n_done, n_err;
  logic [7:0]       n_addr, n_rv, n_ld;
  logic [7:0]       ea;
  logic             in_range;

  assign ea       = calc_ea(base, offset);
  assign in_range = {1'b0, ea} < DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      Rm        <= 1'b0;
      Wm        <= 1'b0;
      address   <= '0;
      RegVal    <= '0;
      load_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= n_state;
      cnt       <= n_cnt;
      Rm        <= n_rm;
      Wm        <= n_wm;
      address   <= n_addr;
      RegVal    <= n_rv;
      load_data <= n_ld;
      busy      <= n_busy;
      done      <= n_done;
      err       <= n_err;
    end
  end

  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_rm    = Rm;
    n_wm    = Wm;
    n_addr  = address;
    n_rv    = RegVal;
    n_ld    = load_data;
    n_busy  = busy;
    n_done  = 1'b0;
    n_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          n_busy = 1'b1;
          if (in_range) begin
            n_addr  = ea;
            n_wm    = is_store;
            n_rm    = ~is_store;
            n_cnt   = CNT_INIT;
            n_state = S_ACCESS;
            if (is_store) n_rv = store_data;
          end else begin
            // Out-of-range: skip the bus entirely
            n_done  = 1'b1;
            n_err   = 1'b1;
            n_state = S_DONE;
          end
        end
      end
      S_ACCESS: begin
        if (cnt != '0) begin
          n_cnt = cnt - 1'b1;
        end else begin
          if (Rm) n_ld = Data_out;
          n_rm    = 1'b0;
          n_wm    = 1'b0;
          n_done  = 1'b1;
          n_state = S_DONE;
        end
      end
      S_DONE: begin
        n_rm    = 1'b0;
        n_wm    = 1'b0;
        n_busy  = 1'b0;
        n_state = S_IDLE;
      end
      default: begin
        n_rm    = 1'b0;
        n_wm    = 1'b0;
        n_busy  = 1'b0;
        n_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench: two parameterisations driven in lockstep,
// checked against a memory/transaction model.
module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       is_store = 1'b0;
  logic [7:0] base = '0;
  logic [7:0] offset = '0;
  logic [7:0] store_data = '0;
  logic [1:0] rm, wm, busy, done, err;
  logic [7:0] addr [2];
  logic [7:0] rv [2];
  logic [7:0] ld [2];
  logic [7:0] dout [2];
  logic [7:0] mem [2][256];
  logic       mem_clr = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [2][256];
  logic [7:0] e_addr [2];
  logic [7:0] e_rv [2];
  logic [7:0] e_ld [2];

  always #5 clk = ~clk;

  mem_access_unit #(.ACC_CYCLES(1), .MEM_DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .base(base), .offset(offset), .store_data(store_data),
    .Data_out(dout[0]), .Rm(rm[0]), .Wm(wm[0]),
    .address(addr[0]), .RegVal(rv[0]), .load_data(ld[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  mem_access_unit #(.ACC_CYCLES(3), .MEM_DEPTH(256)) u_b (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .base(base), .offset(offset), .store_data(store_data),
    .Data_out(dout[1]), .Rm(rm[1]), .Wm(wm[1]),
    .address(addr[1]), .RegVal(rv[1]), .load_data(ld[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  // Synchronous-write responder standing in for memorydata
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_clr) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= 8'h00;
      end else if (wm[k]) begin
        mem[k][addr[k]] <= rv[k];
      end
    end
  end

  assign dout[0] = mem[0][addr[0]];
  assign dout[1] = mem[1][addr[1]];

  function automatic int acc_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 256;
  endfunction

  task automatic chk(input string tag, input int k,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%0h expected=%0h",
             tag, k, obs, exp);
    end
  endtask

  task automatic txn(input bit st, input logic [7:0] b,
                     input logic [7:0] o, input logic [7:0] d,
                     input bit inject);
    int ea, n;
    bit ok [2];
    int lat [2];
    int dcnt [2], dn [2], rmc [2], wmc [2], viol [2];
    bit errseen [2], held [2];
    logic [7:0] h_addr [2], h_rv [2];
    ea = (int'(b) + int'(o)) % 256;
    for (int k = 0; k < 2; k++) begin
      ok[k] = ea < depth_of(k);
      lat[k] = ok[k] ? acc_of(k) + 1 : 1;
      dcnt[k] = 0; dn[k] = 0; rmc[k] = 0; wmc[k] = 0;
      viol[k] = 0; errseen[k] = 0; held[k] = 0;
      h_addr[k] = '0; h_rv[k] = '0;
    end
    @(negedge clk);
    start = 1'b1; is_store = st;
    base = b; offset = o; store_data = d;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1 && inject) begin
        start = 1'b1; is_store = ~st;
        base = b + 8'h40; store_data = ~d;
      end else begin
        start = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        if (rm[k] && wm[k]) viol[k]++;
        if ((err[k] && !done[k]) || ((rm[k] || wm[k]) && done[k]))
          viol[k]++;
        if (rm[k]) rmc[k]++;
        if (wm[k]) wmc[k]++;
        if (done[k]) begin
          dcnt[k]++; dn[k] = n; errseen[k] = err[k];
        end
        if (rm[k] || wm[k]) begin
          if (!held[k]) begin
            held[k] = 1; h_addr[k] = addr[k]; h_rv[k] = rv[k];
          end else if (addr[k] !== h_addr[k] || rv[k] !== h_rv[k]) begin
            viol[k]++;
          end
        end
      end
      if (n > 1 && busy == 2'b00) break;
    end
    chk("timeout", 0, 32'(n < 40), 32'd1);
    for (int k = 0; k < 2; k++) begin
      if (ok[k]) begin
        e_addr[k] = 8'(ea);
        if (st) begin
          e_rv[k] = d; mm[k][ea] = d;
        end else begin
          e_ld[k] = mm[k][ea];
        end
      end
      chk("done_count", k, dcnt[k], 1);
      chk("latency", k, dn[k], lat[k]);
      chk("err", k, 32'(errseen[k]), 32'(!ok[k]));
      chk("rm_cycles", k, rmc[k], (ok[k] && !st) ? acc_of(k) : 0);
      chk("wm_cycles", k, wmc[k], (ok[k] && st) ? acc_of(k) : 0);
      chk("address", k, 32'(addr[k]), 32'(e_addr[k]));
      chk("regval", k, 32'(rv[k]), 32'(e_rv[k]));
      chk("load_data", k, 32'(ld[k]), 32'(e_ld[k]));
      chk("invariants", k, viol[k], 0);
    end
  endtask

  initial begin
    bit st, inj;
    logic [7:0] b, o, d;
    for (int k = 0; k < 2; k++) begin
      e_addr[k] = '0; e_rv[k] = '0; e_ld[k] = '0;
      for (int a = 0; a < 256; a++) mm[k][a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rmwm", k, 32'({rm[k], wm[k]}), 0);
      chk("rst_flags", k, 32'({busy[k], done[k], err[k]}), 0);
      chk("rst_regs", k, {8'h0, addr[k], rv[k], ld[k]}, 0);
    end
    mem_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    txn(1'b1, 8'h00, 8'h00, 8'h01, 1'b0);
    txn(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    txn(1'b1, 8'hF0, 8'h11, 8'h23, 1'b0);
    txn(1'b0, 8'h01, 8'h00, 8'h00, 1'b0);
    txn(1'b0, 8'h11, 8'h00, 8'h00, 1'b0);
    txn(1'b1, 8'h0E, 8'h00, 8'h0E, 1'b0);
    txn(1'b0, 8'h07, 8'h07, 8'h00, 1'b0);
    txn(1'b1, 8'h05, 8'h03, 8'hAA, 1'b1);
    txn(1'b0, 8'h04, 8'h04, 8'h00, 1'b1);

    // Reset while both units are mid-store
    @(negedge clk);
    start = 1'b1; is_store = 1'b1;
    base = 8'h02; offset = 8'h01; store_data = 8'h77;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_wm", 0, 32'(wm), 32'd3);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_rmwm", k, 32'({rm[k], wm[k]}), 0);
      chk("async_busy", k, 32'(busy[k]), 0);
      chk("async_regs", k, {8'h0, addr[k], rv[k], ld[k]}, 0);
      e_addr[k] = '0; e_rv[k] = '0; e_ld[k] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 8'h02, 8'h01, 8'h00, 1'b0);
    txn(1'b1, 8'h02, 8'h01, 8'h5C, 1'b0);
    txn(1'b0, 8'h03, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom);
      d = 8'($urandom);
      inj = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) != 0) begin
        b = 8'($urandom_range(0, 8));
        o = 8'($urandom_range(0, 7));
      end else begin
        b = 8'($urandom);
        o = 8'($urandom);
      end
      txn(st, b, o, d, inj);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
